// File: rtl/key_event_queue_pkg.sv
// Shared types and defaults for the key event front end.
// Optional feature macro used by the top level: KEY_AUTOREPEAT_EN.
package key_event_pkg;

    localparam int N_KEYS_DEF          = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int FIFO_DEPTH_DEF      = 4;
    localparam int REPEAT_DELAY_DEF    = 64;
    localparam int REPEAT_PERIOD_DEF   = 16;

    // Stored code field is sized for up to 256 keys; the port carries only KEY_W bits.
    localparam int CODE_MAX_W = 8;

    typedef struct packed {
        logic                  shift;
        logic [CODE_MAX_W-1:0] code;
    } key_event_t;

    function automatic int key_w(input int n_keys);
        return (n_keys <= 1) ? 1 : $clog2(n_keys);
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event stream from the key front end to the calculator core.
interface key_event_queue_if #(
    parameter int KEY_W = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic [KEY_W-1:0] ev_code;
    logic             ev_shift;

    modport master (output ev_valid, output ev_code, output ev_shift, input  ev_ready);
    modport slave  (input  ev_valid, input  ev_code, input  ev_shift, output ev_ready);
endinterface

// File: rtl/key_event_queue_debounce.sv
// One switch: 2-flop synchroniser, stability counter and a one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        rise_d  = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                state_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = state_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/key_event_queue.sv
// Key front end: debounce, lowest-index pick, one-shot shift and event FIFO.
// Define KEY_AUTOREPEAT_EN to build the auto-repeat generator.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              sht_in,
    key_event_queue_if.master ev,
    output logic              shift_armed,
    output logic              fifo_full,
    output logic              dropped
);
    localparam int KEY_W = key_w(N_KEYS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_KEYS-1:0] key_level, key_rise;
    logic              sht_level, sht_rise;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst(rst), .raw_i(key_in[i]),
            .level_o(key_level[i]), .rise_o(key_rise[i])
        );
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shift (
        .clk(clk), .rst(rst), .raw_i(sht_in), .level_o(sht_level), .rise_o(sht_rise)
    );

    logic [KEY_W-1:0] pick_code;
    logic             any_press, multi_press;

    always_comb begin
        pick_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_rise[i]) pick_code = KEY_W'(i);
        end
    end

    assign any_press   = |key_rise;
    assign multi_press = (key_rise & (key_rise - N_KEYS'(1))) != '0;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_DELAY + 1);

    logic [KEY_W-1:0]  rep_code, rep_code_q;
    logic              rep_held, rep_held_q, rep_new, rep_fire;
    logic [RCNT_W-1:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
        rep_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_level[i]) rep_code = KEY_W'(i);
        end
    end

    assign rep_held = |key_level;
    assign rep_new  = !rep_held_q || (rep_code_q != rep_code);
    assign rep_fire = rep_held && !rep_new && (rep_cnt_q == RCNT_W'(REPEAT_DELAY));

    // Counter tracks cycles since the held key went high; after a repeat it is
    // rewound so the next match lands REPEAT_PERIOD cycles later.
    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (!rep_held)     rep_cnt_d = '0;
        else if (rep_new)  rep_cnt_d = RCNT_W'(1);
        else if (rep_fire) rep_cnt_d = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_held_q <= 1'b0;
            rep_code_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            rep_held_q <= rep_held;
            rep_code_q <= rep_code;
            rep_cnt_q  <= rep_cnt_d;
        end
    end
`endif

    logic                 shift_armed_q, shift_armed_d, shift_now;
    logic                 dropped_q, dropped_d;
    logic                 push_req, push_ok, pop;
    key_event_t           push_ev, head;
    logic [PTR_W:0]       count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    key_event_t           mem [FIFO_DEPTH];

    assign pop       = ev.ev_valid && ev.ev_ready;
    assign shift_now = shift_armed_q ^ sht_rise;

    // A shift press in the same cycle as a key press is applied before the key.
    always_comb begin
        push_req      = 1'b0;
        push_ev       = '0;
        shift_armed_d = shift_now;
        dropped_d     = dropped_q;
        if (any_press) begin
            push_req      = 1'b1;
            push_ev.shift = shift_now;
            push_ev.code  = CODE_MAX_W'(pick_code);
            shift_armed_d = 1'b0;
            if (multi_press) dropped_d = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_fire) begin
            push_req     = 1'b1;
            push_ev.code = CODE_MAX_W'(rep_code);
        end
`endif
        push_ok = push_req && (!fifo_full || pop);
        if (push_req && !push_ok) dropped_d = 1'b1;
        count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_armed_q <= 1'b0;
            dropped_q     <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            shift_armed_q <= shift_armed_d;
            dropped_q     <= dropped_d;
            count_q       <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_ev;
    end

    assign head        = mem[rd_ptr_q];
    assign ev.ev_valid = (count_q != '0);
    assign ev.ev_code  = ev.ev_valid ? head.code[KEY_W-1:0] : '0;
    assign ev.ev_shift = ev.ev_valid & head.shift;
    assign fifo_full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign shift_armed = shift_armed_q;
    assign dropped     = dropped_q;

    logic cfg_unused;
`ifdef KEY_AUTOREPEAT_EN
    assign cfg_unused = ^{sht_level, head.code};
`else
    localparam int REPEAT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
    assign cfg_unused = ^{sht_level, key_level, head.code};
`endif
endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_key_event_queue;
    import key_event_pkg::*;

    localparam int N  = 10;
    localparam int DB = 4;
    localparam int FD = 4;
    localparam int KW = 4;

    typedef struct {
        logic shift;
        int   code;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_in;
    logic         sht_in;
    logic         shift_armed, fifo_full, dropped;

    key_event_queue_if #(.KEY_W(KW)) ev_if ();

    key_event_queue #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .sht_in(sht_in), .ev(ev_if),
        .shift_armed(shift_armed), .fifo_full(fifo_full), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic shift, input int code);
        exp_t e;
        e.shift = shift;
        e.code  = code;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head event is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got code=%0d shift=%0d, none expected",
                         ev_if.ev_code, ev_if.ev_shift);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ev_code", ev_if.ev_code, e.code);
                check("ev_shift", ev_if.ev_shift, e.shift);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_keys(input logic [N-1:0] mask, input int hold);
        key_in = mask;
        tick(hold);
        key_in = '0;
        tick(12);
    endtask

    task automatic press_shift(input int hold);
        sht_in = 1'b1;
        tick(hold);
        sht_in = 1'b0;
        tick(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        rst    = 1'b1;
        key_in = '0;
        sht_in = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick(3);
        check("rst_ev_valid", ev_if.ev_valid, 0);
        check("rst_shift_armed", shift_armed, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_dropped", dropped, 0);
        rst = 1'b0;
        tick(1);

        // Latency: key 8 first sampled at edge t, ev_valid after edge t+7.
        expect_ev(1'b0, 8);
        key_in[8] = 1'b1;
        n = 0;
        found = 0;
        while (n < 40 && !found) begin
            tick(1);
            n++;
            if (ev_if.ev_valid) found = 1;
        end
        check("latency_edges", n - 1, 7);
        tick(1);
        check("single_cycle_valid", ev_if.ev_valid, 0);
        key_in = '0;
        tick(12);

        // One-shot shift attached to the next key.
        press_shift(10);
        check("shift_armed_set", shift_armed, 1);
        expect_ev(1'b1, 3);
        press_keys(N'(1) << 3, 10);
        check("shift_armed_clear", shift_armed, 0);

        // Two shifts disarm; simultaneous shift+key applies shift first.
        press_shift(10);
        press_shift(10);
        check("shift_disarmed", shift_armed, 0);
        expect_ev(1'b0, 0);
        press_keys(N'(1), 10);
        expect_ev(1'b1, 6);
        sht_in = 1'b1;
        key_in = N'(1) << 6;
        tick(10);
        sht_in = 1'b0;
        key_in = '0;
        tick(12);
        check("shift_same_cycle_clear", shift_armed, 0);
        check("dropped_before_multi", dropped, 0);
        expect_ev(1'b0, 2);
        press_keys((N'(1) << 2) | (N'(1) << 5), 10);
        check("dropped_after_multi", dropped, 1);
        check("drained_valid", ev_if.ev_valid, 0);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("dropped_cleared", dropped, 0);

        // Overflow with a stalled consumer, then drain in order.
        ev_if.ev_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) expect_ev(1'b0, k);
            press_keys(N'(1) << k, 10);
        end
        check("full_flag", fifo_full, 1);
        check("full_dropped", dropped, 1);
        check("stalled_valid", ev_if.ev_valid, 1);
        check("stalled_code", ev_if.ev_code, 1);
        tick(5);
        check("stalled_code_stable", ev_if.ev_code, 1);
        ev_if.ev_ready = 1'b1;
        tick(8);
        check("drain_valid", ev_if.ev_valid, 0);
        check("drain_full", fifo_full, 0);

        // Glitch shorter than the debounce window.
        key_in[9] = 1'b1;
        tick(3);
        key_in = '0;
        tick(15);
        check("glitch_no_event", ev_if.ev_valid, 0);

        // Reset with two events queued and shift armed; key 0 held through reset.
        ev_if.ev_ready = 1'b0;
        press_keys(N'(1) << 7, 10);
        press_keys(N'(1) << 8, 10);
        press_shift(10);
        check("prereset_valid", ev_if.ev_valid, 1);
        check("prereset_shift_armed", shift_armed, 1);
        check("prereset_dropped", dropped, 1);
        rst = 1'b1;
        key_in[0] = 1'b1;
        tick(1);
        check("midrst_valid", ev_if.ev_valid, 0);
        check("midrst_dropped", dropped, 0);
        check("midrst_shift_armed", shift_armed, 0);
        check("midrst_full", fifo_full, 0);
        rst = 1'b0;
        exp_q.delete();
        ev_if.ev_ready = 1'b1;
        expect_ev(1'b0, 0);
        tick(12);
        key_in = '0;
        tick(12);

`ifdef KEY_AUTOREPEAT_EN
        begin
            int rep_off[4] = '{20, 28, 36, 44};
            pop_cyc.delete();
            for (int k = 0; k < 5; k++) expect_ev(1'b0, 4);
            key_in[4] = 1'b1;
            tick(50);
            key_in = '0;
            tick(15);
            check("repeat_count", pop_cyc.size(), 5);
            if (pop_cyc.size() == 5) begin
                for (int k = 0; k < 4; k++)
                    check("repeat_offset", pop_cyc[k+1] - pop_cyc[0], rep_off[k]);
            end
            check("repeat_shift_armed", shift_armed, 0);
        end
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
